// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
// Bundles every handshake/bus signal of mem_bus_arbiter. clk and rst are not
// part of the bundle; they stay plain ports on the arbiter.
//
// Signal groups:
//   i_*      instruction-fetch requester (req/addr in, data/ack out)
//   d_*      data requester (req/we/sel/addr/wdata in, rdata/ack out)
//   flush_i  pipeline flush from the control unit
//   m_*      shared memory bus (cyc/stb/we/sel/addr/wdata out, rdata/ack in)
//   stallreq_o, bus_err_o, grant_o  status back to the control unit
//
// Modports:
//   master  the arbiter itself (it masters the shared memory bus)
//   slave   the surrounding environment: CPU requesters, control unit, memory
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic [31:0] i_data_o;
  logic        i_ack_o;

  logic        d_req_i;
  logic        d_we_i;
  logic [3:0]  d_sel_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [31:0] d_rdata_o;
  logic        d_ack_o;

  logic        flush_i;

  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic [31:0] m_rdata_i;
  logic        m_ack_i;

  logic        stallreq_o;
  logic        bus_err_o;
  logic [1:0]  grant_o;

  modport master (
    input  i_req_i, i_addr_i,
    output i_data_o, i_ack_o,
    input  d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
    output d_rdata_o, d_ack_o,
    input  flush_i,
    output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_addr_o, m_wdata_o,
    input  m_rdata_i, m_ack_i,
    output stallreq_o, bus_err_o, grant_o
  );

  modport slave (
    output i_req_i, i_addr_i,
    input  i_data_o, i_ack_o,
    output d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
    input  d_rdata_o, d_ack_o,
    output flush_i,
    input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_addr_o, m_wdata_o,
    output m_rdata_i, m_ack_i,
    input  stallreq_o, bus_err_o, grant_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one memory bus between an instruction-fetch port and a data port.
// One transaction at a time; all bus outputs are registered and held stable
// for the whole transaction. Completion is reported with a one-cycle ack pulse
// on the owning port one cycle after m_ack_i. A flushed fetch that is already
// on the bus is drained silently. A watchdog ends a transaction that gets no
// m_ack_i for TIMEOUT_CYC bus cycles and pulses bus_err_o.
//
// Ports:
//   clk   in  sole clock, rising edge
//   rst   in  synchronous reset, active low
//   bus   mem_bus_arbiter_if.master (requesters, flush, memory bus, status)
//
// Parameters:
//   TIMEOUT_CYC  bus cycles without m_ack_i before forced termination
//                (0 disables the watchdog)
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, simultaneous requests alternate based on
//                       the last grant; otherwise data always beats fetch.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;
  logic [7:0]  w_cnt_inc;

  logic        r_cyc;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        r_i_ack;
  logic        r_d_ack;
  logic        r_bus_err;
  logic [31:0] r_i_data;
  logic [31:0] r_d_rdata;

  logic        w_i_ack_next;
  logic        w_d_ack_next;
  logic        w_err_next;
  logic [31:0] w_i_data_next;
  logic [31:0] w_d_rdata_next;

  logic        w_gnt_i;
  logic        w_gnt_d;
  logic        w_end;
  logic        w_i_elig;
  logic        w_d_elig;
  logic        w_pick_d;
  logic        w_timeout;

  // A port that is being acked this cycle still shows its old request; it is
  // masked so the same access is not issued twice.
  assign w_i_elig = bus.i_req_i & ~r_i_ack & ~bus.flush_i;
  assign w_d_elig = bus.d_req_i & ~r_d_ack;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;  // 1 = data port owned the most recent grant

  assign w_pick_d = w_d_elig & (~w_i_elig | ~r_last_d);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_d <= 1'b0;
    end else if (w_gnt_d) begin
      r_last_d <= 1'b1;
    end else if (w_gnt_i) begin
      r_last_d <= 1'b0;
    end
  end
`else
  assign w_pick_d = w_d_elig;
`endif

  // The counter holds the number of unacknowledged bus cycles already
  // completed; the watchdog fires when the cycle now ending would make that
  // count reach TIMEOUT_CYC, so exactly TIMEOUT_CYC bus cycles are spent.
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_timeout = (TIMEOUT_CYC != 8'd0) && (w_cnt_inc == TIMEOUT_CYC);

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_gnt_i        = 1'b0;
    w_gnt_d        = 1'b0;
    w_end          = 1'b0;
    w_i_ack_next   = 1'b0;
    w_d_ack_next   = 1'b0;
    w_err_next     = 1'b0;
    w_i_data_next  = r_i_data;
    w_d_rdata_next = r_d_rdata;

    case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_gnt_d      = 1'b1;
          w_cnt_next   = 8'd0;
          w_state_next = GNT_D;
        end else if (w_i_elig) begin
          w_gnt_i      = 1'b1;
          w_cnt_next   = 8'd0;
          w_state_next = GNT_I;
        end
      end

      GNT_I: begin
        if (bus.m_ack_i) begin
          w_end        = 1'b1;
          w_state_next = IDLE;
          // A flush arriving with the ack discards the fetched word.
          if (!bus.flush_i) begin
            w_i_ack_next  = 1'b1;
            w_i_data_next = bus.m_rdata_i;
          end
        end else if (w_timeout) begin
          w_end        = 1'b1;
          w_err_next   = 1'b1;
          w_state_next = IDLE;
          if (!bus.flush_i) begin
            w_i_ack_next  = 1'b1;
            w_i_data_next = 32'h0;
          end
        end else begin
          w_cnt_next = w_cnt_inc;
          // The access is already on the bus and cannot be withdrawn.
          if (bus.flush_i) begin
            w_state_next = DRAIN;
          end
        end
      end

      GNT_D: begin
        if (bus.m_ack_i) begin
          w_end          = 1'b1;
          w_d_ack_next   = 1'b1;
          w_d_rdata_next = bus.m_rdata_i;
          w_state_next   = IDLE;
        end else if (w_timeout) begin
          w_end          = 1'b1;
          w_err_next     = 1'b1;
          w_d_ack_next   = 1'b1;
          w_d_rdata_next = 32'h0;
          w_state_next   = IDLE;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      DRAIN: begin
        if (bus.m_ack_i) begin
          w_end        = 1'b1;
          w_state_next = IDLE;
        end else if (w_timeout) begin
          w_end        = 1'b1;
          w_err_next   = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_sel     <= 4'h0;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_bus_err <= 1'b0;
      r_i_data  <= 32'h0;
      r_d_rdata <= 32'h0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_i_ack   <= w_i_ack_next;
      r_d_ack   <= w_d_ack_next;
      r_bus_err <= w_err_next;
      r_i_data  <= w_i_data_next;
      r_d_rdata <= w_d_rdata_next;

      if (w_gnt_d) begin
        r_cyc   <= 1'b1;
        r_we    <= bus.d_we_i;
        r_sel   <= bus.d_sel_i;
        r_addr  <= bus.d_addr_i;
        r_wdata <= bus.d_wdata_i;
      end else if (w_gnt_i) begin
        // Fetches are always full-word reads.
        r_cyc   <= 1'b1;
        r_we    <= 1'b0;
        r_sel   <= 4'hF;
        r_addr  <= bus.i_addr_i;
        r_wdata <= 32'h0;
      end else if (w_end) begin
        r_cyc <= 1'b0;
      end
    end
  end

  assign bus.m_cyc_o   = r_cyc;
  assign bus.m_stb_o   = r_cyc;
  assign bus.m_we_o    = r_we;
  assign bus.m_sel_o   = r_sel;
  assign bus.m_addr_o  = r_addr;
  assign bus.m_wdata_o = r_wdata;

  assign bus.i_ack_o   = r_i_ack;
  assign bus.i_data_o  = r_i_data;
  assign bus.d_ack_o   = r_d_ack;
  assign bus.d_rdata_o = r_d_rdata;
  assign bus.bus_err_o = r_bus_err;

  assign bus.stallreq_o = (bus.i_req_i & ~r_i_ack) | (bus.d_req_i & ~r_d_ack);

  always_comb begin
    case (r_state)
      GNT_I, DRAIN: bus.grant_o = 2'b01;
      GNT_D:        bus.grant_o = 2'b10;
      default:      bus.grant_o = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter built with TIMEOUT_CYC = 4. One table row
// per clock cycle: inputs are driven just after the rising edge and outputs are
// compared on the following falling edge, so each row's expected outputs are
// those of the cycle in which its inputs are applied. Timeout and reset-abort
// are exercised by hand-written sequences after the table.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus_if ();

  mem_bus_arbiter #(.TIMEOUT_CYC(8'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    string       nm;
    logic        rs;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dwe;
    logic [3:0]  dsel;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        fl;
    logic        ma;
    logic [31:0] mrd;
    logic        e_cyc;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_iack;
    logic [31:0] e_idata;
    logic        e_dack;
    logic [31:0] e_drd;
    logic        e_err;
    logic [1:0]  e_gnt;
    logic        e_stall;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input string nm, input logic rs,
                     input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dwe, input logic [3:0] dsel,
                     input logic [31:0] da, input logic [31:0] dwd,
                     input logic fl, input logic ma, input logic [31:0] mrd,
                     input logic e_cyc, input logic e_we, input logic [3:0] e_sel,
                     input logic [31:0] e_addr, input logic [31:0] e_wdata,
                     input logic e_iack, input logic [31:0] e_idata,
                     input logic e_dack, input logic [31:0] e_drd,
                     input logic e_err, input logic [1:0] e_gnt, input logic e_stall);
    vec_t v;
    v.nm = nm; v.rs = rs; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe;
    v.dsel = dsel; v.da = da; v.dwd = dwd; v.fl = fl; v.ma = ma; v.mrd = mrd;
    v.e_cyc = e_cyc; v.e_we = e_we; v.e_sel = e_sel; v.e_addr = e_addr;
    v.e_wdata = e_wdata; v.e_iack = e_iack; v.e_idata = e_idata;
    v.e_dack = e_dack; v.e_drd = e_drd; v.e_err = e_err; v.e_gnt = e_gnt;
    v.e_stall = e_stall;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst              = v.rs;
    bus_if.i_req_i   = v.ir;
    bus_if.i_addr_i  = v.ia;
    bus_if.d_req_i   = v.dr;
    bus_if.d_we_i    = v.dwe;
    bus_if.d_sel_i   = v.dsel;
    bus_if.d_addr_i  = v.da;
    bus_if.d_wdata_i = v.dwd;
    bus_if.flush_i   = v.fl;
    bus_if.m_ack_i   = v.ma;
    bus_if.m_rdata_i = v.mrd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int ncyc;
    bit seen;

    // Expected columns: cyc we sel addr wdata | iack idata | dack drd | err gnt stall
    add("reset",        0, 0,32'h0,   0,0,4'h0,32'h0,0,             0,0,32'h0,        0,0,4'h0,32'h0,0,               0,32'h0,0,32'h0,                     0,2'd0,0);
    add("i_req",        1, 1,32'h100, 0,0,4'h0,32'h0,0,             0,0,32'h0,        0,0,4'h0,32'h0,0,               0,32'h0,0,32'h0,                     0,2'd0,1);
    add("i_stb",        1, 1,32'h100, 0,0,4'h0,32'h0,0,             0,1,32'hDEADBEEF, 1,0,4'hF,32'h100,0,             0,32'h0,0,32'h0,                     0,2'd1,1);
    add("i_ack",        1, 1,32'h100, 0,0,4'h0,32'h0,0,             0,0,32'h0,        0,0,4'h0,32'h0,0,               1,32'hDEADBEEF,0,32'h0,              0,2'd0,0);
    add("i_done",       1, 0,32'h0,   0,0,4'h0,32'h0,0,             0,0,32'h0,        0,0,4'h0,32'h0,0,               0,32'hDEADBEEF,0,32'h0,              0,2'd0,0);
    add("pair",         1, 1,32'h200, 1,1,4'hF,32'h300,32'hCAFE0001,0,0,32'h0,        0,0,4'h0,32'h0,0,               0,32'hDEADBEEF,0,32'h0,              0,2'd0,1);
    add("pair_d_stb",   1, 1,32'h200, 1,1,4'hF,32'h300,32'hCAFE0001,0,1,32'h11111111, 1,1,4'hF,32'h300,32'hCAFE0001,  0,32'hDEADBEEF,0,32'h0,              0,2'd2,1);
    add("pair_d_ack",   1, 1,32'h200, 1,1,4'hF,32'h300,32'hCAFE0001,0,0,32'h0,        0,0,4'h0,32'h0,0,               0,32'hDEADBEEF,1,32'h11111111,       0,2'd0,1);
    add("pair_i_stb",   1, 1,32'h200, 0,0,4'h0,32'h0,0,             0,1,32'h12345678, 1,0,4'hF,32'h200,0,             0,32'hDEADBEEF,0,32'h11111111,       0,2'd1,1);
    add("pair_i_ack",   1, 1,32'h200, 0,0,4'h0,32'h0,0,             0,0,32'h0,        0,0,4'h0,32'h0,0,               1,32'h12345678,0,32'h11111111,       0,2'd0,0);
    add("pair_done",    1, 0,32'h0,   0,0,4'h0,32'h0,0,             0,0,32'h0,        0,0,4'h0,32'h0,0,               0,32'h12345678,0,32'h11111111,       0,2'd0,0);
    add("fl_req",       1, 1,32'h400, 0,0,4'h0,32'h0,0,             0,0,32'h0,        0,0,4'h0,32'h0,0,               0,32'h12345678,0,32'h11111111,       0,2'd0,1);
    add("fl_flush",     1, 1,32'h400, 0,0,4'h0,32'h0,0,             1,0,32'h0,        1,0,4'hF,32'h400,0,             0,32'h12345678,0,32'h11111111,       0,2'd1,1);
    add("fl_drain",     1, 0,32'h0,   0,0,4'h0,32'h0,0,             0,0,32'h0,        1,0,4'hF,32'h400,0,             0,32'h12345678,0,32'h11111111,       0,2'd1,0);
    add("fl_drain_ack", 1, 0,32'h0,   0,0,4'h0,32'h0,0,             0,1,32'hBADBAD00, 1,0,4'hF,32'h400,0,             0,32'h12345678,0,32'h11111111,       0,2'd1,0);
    add("fl_idle",      1, 0,32'h0,   0,0,4'h0,32'h0,0,             0,0,32'h0,        0,0,4'h0,32'h0,0,               0,32'h12345678,0,32'h11111111,       0,2'd0,0);
    add("fl_block",     1, 1,32'h800, 0,0,4'h0,32'h0,0,             1,0,32'h0,        0,0,4'h0,32'h0,0,               0,32'h12345678,0,32'h11111111,       0,2'd0,1);
    add("fl_block2",    1, 1,32'h800, 0,0,4'h0,32'h0,0,             1,0,32'h0,        0,0,4'h0,32'h0,0,               0,32'h12345678,0,32'h11111111,       0,2'd0,1);
    add("fl_release",   1, 0,32'h0,   0,0,4'h0,32'h0,0,             0,0,32'h0,        0,0,4'h0,32'h0,0,               0,32'h12345678,0,32'h11111111,       0,2'd0,0);
    add("d_load",       1, 0,32'h0,   1,0,4'h3,32'h500,0,           0,0,32'h0,        0,0,4'h0,32'h0,0,               0,32'h12345678,0,32'h11111111,       0,2'd0,1);
    add("d_flush",      1, 0,32'h0,   1,0,4'h3,32'h500,0,           1,0,32'h0,        1,0,4'h3,32'h500,0,             0,32'h12345678,0,32'h11111111,       0,2'd2,1);
    add("d_ack_in",     1, 0,32'h0,   1,0,4'h3,32'h500,0,           0,1,32'h0000A5A5, 1,0,4'h3,32'h500,0,             0,32'h12345678,0,32'h11111111,       0,2'd2,1);
    add("d_ack",        1, 0,32'h0,   1,0,4'h3,32'h500,0,           0,0,32'h0,        0,0,4'h0,32'h0,0,               0,32'h12345678,1,32'h0000A5A5,       0,2'd0,0);
    add("d_done",       1, 0,32'h0,   0,0,4'h0,32'h0,0,             0,0,32'h0,        0,0,4'h0,32'h0,0,               0,32'h12345678,0,32'h0000A5A5,       0,2'd0,0);

    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k]);
      @(negedge clk);
      chk({vecs[k].nm, ".cyc"},   {31'b0, bus_if.m_cyc_o},    {31'b0, vecs[k].e_cyc});
      chk({vecs[k].nm, ".stb"},   {31'b0, bus_if.m_stb_o},    {31'b0, vecs[k].e_cyc});
      chk({vecs[k].nm, ".iack"},  {31'b0, bus_if.i_ack_o},    {31'b0, vecs[k].e_iack});
      chk({vecs[k].nm, ".idata"}, bus_if.i_data_o,            vecs[k].e_idata);
      chk({vecs[k].nm, ".dack"},  {31'b0, bus_if.d_ack_o},    {31'b0, vecs[k].e_dack});
      chk({vecs[k].nm, ".drd"},   bus_if.d_rdata_o,           vecs[k].e_drd);
      chk({vecs[k].nm, ".err"},   {31'b0, bus_if.bus_err_o},  {31'b0, vecs[k].e_err});
      chk({vecs[k].nm, ".gnt"},   {30'b0, bus_if.grant_o},    {30'b0, vecs[k].e_gnt});
      chk({vecs[k].nm, ".stall"}, {31'b0, bus_if.stallreq_o}, {31'b0, vecs[k].e_stall});
      if (vecs[k].e_cyc || k == 0) begin
        chk({vecs[k].nm, ".addr"}, bus_if.m_addr_o,         vecs[k].e_addr);
        chk({vecs[k].nm, ".we"},   {31'b0, bus_if.m_we_o},  {31'b0, vecs[k].e_we});
      end
      if (vecs[k].e_gnt == 2'd2 || k == 0)
        chk({vecs[k].nm, ".sel"}, {28'b0, bus_if.m_sel_o}, {28'b0, vecs[k].e_sel});
      if (vecs[k].e_we || k == 0)
        chk({vecs[k].nm, ".wdata"}, bus_if.m_wdata_o, vecs[k].e_wdata);
      $display("row %0d %s: cyc=%0b addr=%h gnt=%0d iack=%0b dack=%0b err=%0b stall=%0b",
               k, vecs[k].nm, bus_if.m_cyc_o, bus_if.m_addr_o, bus_if.grant_o,
               bus_if.i_ack_o, bus_if.d_ack_o, bus_if.bus_err_o, bus_if.stallreq_o);
      next_cycle();
    end

    // Load that is never acknowledged: watchdog ends it after 4 bus cycles.
    bus_if.d_req_i  = 1'b1;
    bus_if.d_we_i   = 1'b0;
    bus_if.d_sel_i  = 4'hF;
    bus_if.d_addr_i = 32'h600;
    bus_if.m_ack_i  = 1'b0;
    ncyc = 0;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      if (bus_if.bus_err_o) begin
        seen = 1'b1;
        chk("to.dack", {31'b0, bus_if.d_ack_o}, 32'd1);
        chk("to.drd",  bus_if.d_rdata_o,        32'h0);
        chk("to.cyc",  {31'b0, bus_if.m_cyc_o}, 32'd0);
        chk("to.gnt",  {30'b0, bus_if.grant_o}, 32'd0);
      end else if (bus_if.m_cyc_o) begin
        ncyc++;
        chk("to.no_early_ack", {31'b0, bus_if.d_ack_o}, 32'd0);
      end
      next_cycle();
    end
    chk("to.seen",       {31'b0, seen}, 32'd1);
    chk("to.bus_cycles", ncyc,          32'd4);
    $display("timeout: bus cycles=%0d err_seen=%0b", ncyc, seen);
    bus_if.d_req_i = 1'b0;
    @(negedge clk);
    chk("to.err_pulse", {31'b0, bus_if.bus_err_o}, 32'd0);
    chk("to.dack_pulse", {31'b0, bus_if.d_ack_o}, 32'd0);
    next_cycle();

    // Reset while a store owns the bus: aborted with no ack and no error.
    bus_if.d_req_i   = 1'b1;
    bus_if.d_we_i    = 1'b1;
    bus_if.d_sel_i   = 4'hC;
    bus_if.d_addr_i  = 32'h700;
    bus_if.d_wdata_i = 32'h77;
    next_cycle();
    @(negedge clk);
    chk("rs.gnt_before", {30'b0, bus_if.grant_o}, 32'd2);
    chk("rs.cyc_before", {31'b0, bus_if.m_cyc_o}, 32'd1);
    rst              = 1'b0;
    bus_if.m_ack_i   = 1'b1;
    bus_if.m_rdata_i = 32'h99;
    next_cycle();
    rst            = 1'b1;
    bus_if.m_ack_i = 1'b0;
    @(negedge clk);
    chk("rs.cyc",   {31'b0, bus_if.m_cyc_o},    32'd0);
    chk("rs.stb",   {31'b0, bus_if.m_stb_o},    32'd0);
    chk("rs.we",    {31'b0, bus_if.m_we_o},     32'd0);
    chk("rs.sel",   {28'b0, bus_if.m_sel_o},    32'd0);
    chk("rs.addr",  bus_if.m_addr_o,            32'h0);
    chk("rs.wdata", bus_if.m_wdata_o,           32'h0);
    chk("rs.dack",  {31'b0, bus_if.d_ack_o},    32'd0);
    chk("rs.iack",  {31'b0, bus_if.i_ack_o},    32'd0);
    chk("rs.idata", bus_if.i_data_o,            32'h0);
    chk("rs.drd",   bus_if.d_rdata_o,           32'h0);
    chk("rs.err",   {31'b0, bus_if.bus_err_o},  32'd0);
    chk("rs.gnt",   {30'b0, bus_if.grant_o},    32'd0);
    chk("rs.stall", {31'b0, bus_if.stallreq_o}, 32'd1);
    $display("reset abort: cyc=%0b gnt=%0d dack=%0b stall=%0b",
             bus_if.m_cyc_o, bus_if.grant_o, bus_if.d_ack_o, bus_if.stallreq_o);
    next_cycle();
    @(negedge clk);
    chk("rs.regrant_gnt",  {30'b0, bus_if.grant_o}, 32'd2);
    chk("rs.regrant_addr", bus_if.m_addr_o,         32'h700);
    chk("rs.regrant_sel",  {28'b0, bus_if.m_sel_o}, 32'hC);
    bus_if.m_ack_i   = 1'b1;
    bus_if.m_rdata_i = 32'h99;
    next_cycle();
    bus_if.m_ack_i = 1'b0;
    @(negedge clk);
    chk("rs.final_dack", {31'b0, bus_if.d_ack_o}, 32'd1);
    chk("rs.final_drd",  bus_if.d_rdata_o,        32'h99);
    $display("post-reset store: dack=%0b drd=%h", bus_if.d_ack_o, bus_if.d_rdata_o);
    bus_if.d_req_i = 1'b0;
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
